data_mem_hs: RTL and testbench

- Parametrised, byte-addressable little-endian data memory for the CPU load/store path.
- Supersedes the combinational-read data RAM with:
  - a valid/ready request port and a response port;
  - configurable read latency;
  - unsigned loads (lbu/lhu) and misalignment error reporting.
- Sits between the execute/memory stage and the register-file writeback mux. One transaction is outstanding at a time.

---
 rtl/data_mem_hs.sv | 122 ++++++++++++
 tb/tb_data_mem_hs.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_hs.sv
// rtl/data_mem_hs.sv - byte-addressable little-endian data memory with valid/ready request and strobed response
module data_mem_hs #(
    parameter int ADDR_W    = 8,
    parameter int RD_LAT    = 1,
    parameter int INIT_ZERO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        cnt;
    logic [31:0]       cap;
    logic [7:0]        mem [DEPTH];

    logic              accept;
    logic              misaligned;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
    logic [31:0]       ld_val;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;

    assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));

    // Aligned accesses never cross the top address, so plain increments suffice.
    assign a1 = req_addr + ADDR_W'(1);
    assign a2 = req_addr + ADDR_W'(2);
    assign a3 = req_addr + ADDR_W'(3);

    always_comb begin
        ld_val = 32'd0;
        if (req_size == 2'b00) begin
            ld_val = {{24{mem[req_addr][7] & ~req_unsigned}}, mem[req_addr]};
        end else if (req_size == 2'b01) begin
            ld_val = {{16{mem[a1][7] & ~req_unsigned}}, mem[a1], mem[req_addr]};
        end else begin
            ld_val = {mem[a3], mem[a2], mem[a1], mem[req_addr]};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (misaligned || req_we || (RD_LAT == 1)) state_nxt = RESP;
                    else                                       state_nxt = WAIT;
                end
            end
            WAIT:    if (cnt == 2'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            cap       <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= 2'(RD_LAT - 1);
                cap <= (misaligned || req_we) ? 32'd0 : ld_val;
                if (state_nxt == RESP) begin
                    rsp_rdata <= (misaligned || req_we) ? 32'd0 : ld_val;
                    rsp_err   <= misaligned;
                end
            end else if (state == WAIT) begin
                if (cnt == 2'd0) begin
                    rsp_rdata <= cap;
                    rsp_err   <= 1'b0;
                end else begin
                    cnt <= cnt - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (INIT_ZERO != 0) ? 8'd0 : 8'(i);
            end
        end else if (accept && req_we && !misaligned) begin
            mem[req_addr] <= req_wdata[7:0];
            if (req_size != 2'b00) mem[a1] <= req_wdata[15:8];
            if (req_size[1]) begin
                mem[a2] <= req_wdata[23:16];
                mem[a3] <= req_wdata[31:24];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_hs.sv
// tb/tb_data_mem_hs.sv - randomized self-checking bench for data_mem_hs at read latencies 1 and 3
module tb_data_mem_hs;

    logic        clk;
    logic [1:0]  reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [1:0]  req_size [2];
    logic [1:0]  req_unsigned;
    logic [7:0]  req_addr [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err;

    int          n_cmp;
    int          n_bad;
    logic [7:0]  mm [2][256];
    int          rl [2];
    logic [31:0] got;

    data_mem_hs #(.ADDR_W(8), .RD_LAT(1), .INIT_ZERO(0)) u_lat1 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0])
    );

    data_mem_hs #(.ADDR_W(8), .RD_LAT(3), .INIT_ZERO(0)) u_lat3 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        for (int i = 0; i < 256; i++) mm[d][i] = 8'(i);
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [1:0] sz,
                                               input bit uns, input logic [7:0] a);
        longint v;
        int     n;
        n = nbytes(sz);
        v = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(mm[d][(int'(a) + k) % 256]) << (8 * k));
        if (!uns && (v >= (longint'(1) << (8 * n - 1)))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    function automatic bit is_mis(input logic [1:0] sz, input logic [7:0] a);
        return (nbytes(sz) == 2 && (a % 2) != 0) || (nbytes(sz) == 4 && (a % 4) != 0);
    endfunction

    task automatic drive(input int d, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [7:0] a, input logic [31:0] wd);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_size[d]     = sz;
        req_unsigned[d] = uns;
        req_addr[d]     = a;
        req_wdata[d]    = wd;
    endtask

    task automatic txn(input int d, input bit we, input logic [1:0] sz, input bit uns,
                       input logic [7:0] a, input logic [31:0] wd, output logic [31:0] obs);
        bit          mis;
        int          n;
        int          expn;
        logic [31:0] exp;
        mis  = is_mis(sz, a);
        exp  = (we || mis) ? 32'd0 : model_load(d, sz, uns, a);
        expn = (we || mis || rl[d] == 1) ? 1 : rl[d] + 1;
        @(negedge clk);
        check("ready_idle", 32'(req_ready[d]), 32'd1);
        drive(d, we, sz, uns, a, wd);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_wdata[d] = $urandom;
        req_addr[d]  = 8'($urandom);
        if (we && !mis) begin
            for (int k = 0; k < nbytes(sz); k++) mm[d][(int'(a) + k) % 256] = wd[8*k +: 8];
        end
        n = 1;
        while (!rsp_valid[d] && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(expn));
        check("rdata", rsp_rdata[d], exp);
        check("err", 32'(rsp_err[d]), 32'(mis));
        obs = rsp_rdata[d];
        @(negedge clk);
        check("strobe_one_cycle", 32'(rsp_valid[d]), 32'd0);
    endtask

    initial begin
        int          seen;
        logic [1:0]  sz;
        logic [7:0]  a;
        n_cmp        = 0;
        n_bad        = 0;
        rl[0]        = 1;
        rl[1]        = 3;
        reset        = 2'b11;
        req_valid    = 2'b00;
        req_we       = 2'b00;
        req_unsigned = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_size[d]  = 2'b00;
            req_addr[d]  = 8'd0;
            req_wdata[d] = 32'd0;
            model_reset(d);
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", 32'(rsp_valid[d]), 32'd0);
            check("rst_rdata", rsp_rdata[d], 32'd0);
            check("rst_err", 32'(rsp_err[d]), 32'd0);
        end
        reset = 2'b00;

        txn(0, 0, 2'b10, 0, 8'h04, 0, got); check("plan_lw04", got, 32'h07060504);
        txn(0, 0, 2'b00, 0, 8'h80, 0, got); check("plan_lb80", got, 32'hFFFFFF80);
        txn(0, 0, 2'b00, 1, 8'h80, 0, got); check("plan_lbu80", got, 32'h00000080);
        txn(0, 0, 2'b01, 0, 8'hFE, 0, got); check("plan_lhFE", got, 32'hFFFFFFFE);
        txn(0, 0, 2'b01, 1, 8'hFE, 0, got); check("plan_lhuFE", got, 32'h0000FFFE);
        txn(1, 0, 2'b10, 0, 8'h02, 0, got); check("plan_mis_lw", got, 32'd0);
        txn(1, 1, 2'b01, 0, 8'h11, 32'hDEADBEEF, got); check("plan_mis_sh", got, 32'd0);
        txn(1, 0, 2'b10, 0, 8'h10, 0, got); check("plan_lw10_clean", got, 32'h13121110);
        txn(0, 1, 2'b01, 0, 8'h10, 32'hABCD1234, got); check("plan_sh_rsp", got, 32'd0);
        txn(0, 0, 2'b10, 0, 8'h10, 0, got); check("plan_lw10", got, 32'h13121234);

        // Request held high across a latency-3 load: one response, ready low for four cycles.
        @(negedge clk);
        drive(1, 0, 2'b10, 0, 8'h20, 0);
        seen = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("hold_ready_low", 32'(req_ready[1]), 32'd0);
            check("hold_valid", 32'(rsp_valid[1]), 32'(c == 4));
            if (rsp_valid[1]) begin
                seen++;
                check("hold_rdata", rsp_rdata[1], 32'h23222120);
            end
        end
        req_valid[1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid[1]) seen++;
        end
        check("hold_one_rsp", 32'(seen), 32'd1);

        for (int i = 0; i < 120; i++) begin
            int d;
            d  = i % 2;
            sz = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) a = is_mis(sz, a) ? (a & ((sz == 2'b00) ? 8'hFF : (sz == 2'b01) ? 8'hFE : 8'hFC)) : a;
            txn(d, 1'($urandom), sz, 1'($urandom), a, $urandom, got);
        end

        // Reset one cycle after accepting a latency-3 load discards it.
        @(negedge clk);
        drive(1, 0, 2'b10, 0, 8'h40, 0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        reset[1]     = 1'b1;
        model_reset(1);
        @(negedge clk);
        check("inrst_valid", 32'(rsp_valid[1]), 32'd0);
        check("inrst_rdata", rsp_rdata[1], 32'd0);
        reset[1] = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid[1]) seen++;
        end
        check("rst_no_rsp", 32'(seen), 32'd0);
        check("rst_ready", 32'(req_ready[1]), 32'd1);
        for (int i = 0; i < 64; i++) begin
            txn(1, 0, 2'b10, 0, 8'(i * 4), 0, got);
            check("rst_image", got, {8'(i * 4 + 3), 8'(i * 4 + 2), 8'(i * 4 + 1), 8'(i * 4)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
